// File: rtl/control_sequencer.sv
// Microcoded control sequencer for the 8-bit core: fetches opcodes into IR and
// steps a fixed micro-sequence per opcode, decoding the datapath control word.
module control_sequencer #(
  parameter int         DATA_BUS_WIDTH = 8,
  parameter logic [3:0] HALT_OPCODE    = 4'hF
) (
  input  logic                      ClkxCI,
  input  logic                      RstxRBI,
  input  logic [DATA_BUS_WIDTH-1:0] DataInxD,
  input  logic                      StallxSI,
  output logic [3:0]                AluOpxS,
  output logic                      MemReqxS,
  output logic [2:0]                MemOpxS,
  output logic                      AddrSrcxS,
  output logic [2:0]                SelInxS,
  output logic [2:0]                SelReg1xS,
  output logic [2:0]                SelReg2xS,
  output logic                      InSourcexS,
  output logic                      RegWritexS,
  output logic                      PcIncxS,
  output logic                      FlagLoadxS,
  output logic                      IllegalxS,
  output logic                      HaltedxS
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC1 = 3'd2,
    EXEC2 = 3'd3,
    HALT  = 3'd4
  } state_e;

  localparam logic [3:0] OPC_NOP = 4'h0;
  localparam logic [3:0] OPC_LDX = 4'h1;
  localparam logic [3:0] OPC_AOP = 4'h2;

  state_e                    state_q, state_d;
  logic [DATA_BUS_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_BUS_WIDTH-1:0] opnd_q, opnd_d;

  logic [3:0] fetch_opc;
  logic       fetch_illegal;
  logic       alu_valid;

  assign fetch_opc     = DataInxD[7:4];
  // Illegal is judged on the byte being fetched, so the pulse lines up with its FETCH cycle.
  assign fetch_illegal = !((fetch_opc == OPC_NOP) || (fetch_opc == OPC_LDX) ||
                           (fetch_opc == OPC_AOP) || (fetch_opc == HALT_OPCODE));
  assign alu_valid     = (ir_q[3:0] != 4'h0) && (ir_q[3:0] != 4'hF);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    opnd_d  = opnd_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (!StallxSI) begin
          ir_d = DataInxD;
          if (fetch_opc == HALT_OPCODE)                             state_d = HALT;
          else if (fetch_opc == OPC_LDX || fetch_opc == OPC_AOP)    state_d = EXEC1;
          else                                                      state_d = FETCH;
        end
      end
      EXEC1: begin
        if (!StallxSI) begin
          if (ir_q[7:4] == OPC_LDX) begin
            state_d = FETCH;
          end else begin
            opnd_d  = DataInxD;
            state_d = EXEC2;
          end
        end
      end
      EXEC2:   state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ClkxCI or negedge RstxRBI) begin
    if (!RstxRBI) begin
      state_q <= IDLE;
      ir_q    <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      opnd_q  <= opnd_d;
    end
  end

  always_comb begin
    AluOpxS    = 4'd0;
    MemReqxS   = 1'b0;
    MemOpxS    = 3'd0;
    AddrSrcxS  = 1'b0;
    SelInxS    = 3'd0;
    SelReg1xS  = 3'd0;
    SelReg2xS  = 3'd0;
    InSourcexS = 1'b0;
    RegWritexS = 1'b0;
    PcIncxS    = 1'b0;
    FlagLoadxS = 1'b0;
    IllegalxS  = 1'b0;
    HaltedxS   = 1'b0;
    case (state_q)
      FETCH: begin
        MemReqxS  = 1'b1;
        AddrSrcxS = 1'b1;
        PcIncxS   = !StallxSI;
        IllegalxS = !StallxSI && fetch_illegal;
      end
      EXEC1: begin
        MemReqxS  = 1'b1;
        AddrSrcxS = 1'b1;
        PcIncxS   = !StallxSI;
        if (ir_q[7:4] == OPC_LDX) begin
          InSourcexS = 1'b1;
          SelInxS    = ir_q[2:0];
          RegWritexS = !StallxSI;
        end
      end
      EXEC2: begin
        AluOpxS    = alu_valid ? ir_q[3:0] : 4'd0;
        SelReg1xS  = opnd_q[2:0];
        SelReg2xS  = opnd_q[5:3];
        SelInxS    = opnd_q[2:0];
        RegWritexS = alu_valid;
        FlagLoadxS = alu_valid;
      end
      HALT:    HaltedxS = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit for the 8-bit core.
- Fetches opcode bytes from the data bus into an instruction register (IR) and steps a hard-wired micro-sequence per opcode.
- Each cycle it drives the control-word fields consumed by the register file, ALU, address mux and memory interface.
- Sits directly upstream of the datapath: it produces every control-word field the datapath executes.

Parameters:
- DATA_BUS_WIDTH, 8, width of the data bus, IR and operand register.
- HALT_OPCODE, 4'hF, upper-nibble opcode that halts the core.

Ports:
- ClkxCI  in  1  clock; all state changes on the rising edge.
- RstxRBI  in  1  asynchronous active-low reset.
- DataInxD  in  DATA_BUS_WIDTH  memory read data; sampled at the end of a non-stalled read cycle.
- StallxSI  in  1  memory wait; holds the current micro-step.
- AluOpxS  out  4  alu_op_e encoding (ALUNOP=0, THR=1, ADD=2 … INC3=14).
- MemReqxS  out  1  memory access request this cycle.
- MemOpxS  out  3  memory_op_e (READ=0, WRITE=1).
- AddrSrcxS  out  1  address_source_sel_e (ADDRESS_REGISTER=0, CONTROL_ADDRESS=1).
- SelInxS  out  3  register_sel_e destination.
- SelReg1xS  out  3  register_sel_e for ALU operand 1.
- SelReg2xS  out  3  register_sel_e for ALU operand 2.
- InSourcexS  out  1  register_in_source_e (ALU=0, BUS=1).
- RegWritexS  out  1  register-file write strobe.
- PcIncxS  out  1  PC increment strobe.
- FlagLoadxS  out  1  ALU flag register load strobe.
- IllegalxS  out  1  one-cycle pulse when an undefined opcode is decoded.
- HaltedxS  out  1  high while in HALT.

Behaviour:
- State register values: IDLE, FETCH, EXEC1, EXEC2, HALT. Registered IR[7:0] and OPND[7:0]. All outputs decode combinationally from state, IR, OPND and StallxSI.
- Reset (async, any time, including mid-instruction): state=IDLE, IR=0, OPND=0. All outputs 0.
- IDLE: all outputs 0; next state is always FETCH.
- FETCH:
  - Drives MemReq=1, MemOp=READ, AddrSrc=CONTROL_ADDRESS, PcInc=1.
  - At the edge: IR<=DataInxD.
  - Next state by IR nibble just loaded (opcode=DataInxD[7:4]):
    - 0 (NOP): FETCH.
    - 1 (LDX): EXEC1.
    - 2 (AOP): EXEC1.
    - HALT_OPCODE: HALT.
    - 3..E (illegal): FETCH, with IllegalxS=1 during that FETCH cycle. IllegalxS is decoded from DataInxD, not the IR.
- LDX, EXEC1:
  - Drives MemReq=1, MemOp=READ, AddrSrc=CONTROL_ADDRESS, InSource=BUS, SelIn=IR[2:0], RegWrite=1, PcInc=1.
  - Next state: FETCH. IR[3] is ignored.
- AOP, EXEC1:
  - Drives MemReq=1, MemOp=READ, AddrSrc=CONTROL_ADDRESS, PcInc=1.
  - At the edge: OPND<=DataInxD. Next state: EXEC2.
- AOP, EXEC2:
  - Drives AluOp=IR[3:0], SelReg1=OPND[2:0], SelReg2=OPND[5:3], SelIn=OPND[2:0], InSource=ALU, RegWrite=1, FlagLoad=1. No memory access.
  - Next state: FETCH.
  - IR[3:0]=0 (ALUNOP) or 15 (undefined ALU op): AluOp=0, RegWrite=0, FlagLoad=0.
- HALT: HaltedxS=1, all other outputs 0; exits only via reset.
- Stall:
  - In any state with MemReq=1, StallxSI=1 holds state, IR and OPND.
  - MemReq, MemOp and AddrSrc stay asserted.
  - RegWrite, PcInc and IllegalxS are forced to 0.
  - StallxSI is ignored in IDLE, EXEC2 and HALT.
- Unused output fields are 0 in every state: REG_A, ALUNOP, READ.
- Latency per instruction, in cycles (no stalls): NOP 1, LDX 2, AOP 3, illegal 1.

Test Plan:
- Reset release, bus=0x00 held -> 1 IDLE cycle, then FETCH every cycle. PcInc=1 each FETCH; RegWrite never asserted.
- Bytes 0x11, 0x5A -> FETCH loads IR=0x11. EXEC1 asserts SelIn=1, InSource=BUS, RegWrite=1, PcInc=1. Next cycle is FETCH.
- Bytes 0x22, 0x08 -> EXEC1 loads OPND=0x08. EXEC2 drives AluOp=2, SelReg1=0, SelReg2=1, SelIn=0, InSource=ALU, RegWrite=1, FlagLoad=1.
- AOP 0x22 with StallxSI=1 for 2 cycles in EXEC1 -> state held 3 cycles with MemReq=1 and PcInc=0 while stalled. OPND is captured only in the non-stalled cycle.
- Byte 0x37 -> IllegalxS pulses for 1 cycle, next state FETCH. Byte 0xF0 -> HaltedxS=1 indefinitely, MemReq=0.
- RstxRBI low asynchronously in EXEC2 -> outputs 0 immediately. After release: IDLE, then FETCH, with IR=0.
